// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with memory-ready timeout and traps
module multicycle_control #(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_JAL      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_cen,
  output logic            mem_wen,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            beq,
  output logic            bne,
  output logic            regdst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            jal,
  output logic            illegal,
  output logic            bus_err,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(8'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(8'h2B);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;

  logic is_rtype, is_j, is_jal, is_beq, is_bne, is_addi, is_lw, is_sw, is_legal;
  logic waiting, timeout_hit;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_j     = (opcode == OP_J);
    is_jal   = EN_JAL && (opcode == OP_JAL);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_addi  = (opcode == OP_ADDI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_legal = is_rtype | is_j | is_jal | is_beq | is_bne | is_addi | is_lw | is_sw;
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    timeout_hit = TIMEOUT_EN && waiting && (wait_q == WAIT_LAST);
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_cen    = 1'b1;
    mem_wen    = 1'b1;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    pc_src     = 2'd0;
    beq        = 1'b0;
    bne        = 1'b0;
    regdst     = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    jal        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_cen   = 1'b0;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        // branch target is precomputed here so EXEC only needs the compare
        alu_src_b = 2'd3;
        if (is_j || is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'd2;
          reg_write = is_jal;
          jal       = is_jal;
          state_d   = S_FETCH;
        end else if (!is_legal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_FETCH;
        if (is_rtype) begin
          alu_op  = 2'b10;
          state_d = S_WB;
        end else if (is_addi || is_lw || is_sw) begin
          alu_src_b = 2'd2;
          state_d   = is_addi ? S_WB : S_MEM;
        end else if (is_beq || is_bne) begin
          alu_op = 2'b01;
          pc_src = 2'd1;
          beq    = is_beq;
          bne    = is_bne;
        end
      end
      S_MEM: begin
        mem_cen = 1'b0;
        iord    = 1'b1;
        mem_wen = !is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        regdst     = is_rtype;
        mem_to_reg = is_lw;
        state_d    = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // reset must suppress every strobe combinationally, e.g. a pending SW write
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_cen    = 1'b1;
      mem_wen    = 1'b1;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'b00;
      pc_src     = 2'd0;
      beq        = 1'b0;
      bne        = 1'b0;
      regdst     = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      jal        = 1'b0;
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    illegal = illegal_q & ~rst;
    bus_err = bus_err_q & ~rst;
    state   = state_q;
  end

endmodule
